// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_ctrl_pkg: shared state encoding and channel constants for the mux scan sequencer
package mux_scan_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;
  localparam int NUM_CHAN = 4;
  localparam logic [1:0] LAST_CHAN = 2'd3;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: control, mux and sample-handshake signals of the scan sequencer
interface mux_scan_ctrl_if #(parameter int WIDTH = 4);
  logic start;
  logic cont;
  logic abort;
  logic ready;
  logic [WIDTH-1:0] mux_data;
  logic s0;
  logic s1;
  logic [WIDTH-1:0] data;
  logic [1:0] chan;
  logic valid;
  logic busy;
  logic done;
  modport master (
    input  start, cont, abort, ready, mux_data,
    output s0, s1, data, chan, valid, busy, done
  );
  modport slave (
    output start, cont, abort, ready, mux_data,
    input  s0, s1, data, chan, valid, busy, done
  );
endinterface

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// dwell_counter: 8-bit settle counter with clear/enable and a DWELL-1 terminal count
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt;
  // clear has priority so the count always restarts from zero on entering settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 8'd0;
    else cnt <= clr ? 8'd0 : en ? cnt + 8'd1 : cnt;
  end
  assign tc = en && cnt == 8'(DWELL - 1);
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the mux select through channels 0..3, samples after a settle time, hands samples downstream
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_scan_ctrl_if.master    bus
);
  state_t state;
  logic [1:0] sel;
  logic tc;
  assign bus.s0 = sel[0];
  assign bus.s1 = sel[1];
  dwell_counter #(.DWELL(DWELL)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != ST_SETTLE || tc),
    .en   (state == ST_SETTLE),
    .tc   (tc)
  );
  // sequencer: abort beats everything; select only changes on start or a completed handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= 2'd0;
      bus.data  <= '0;
      bus.chan  <= 2'd0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.abort) begin
        state     <= ST_IDLE;
        sel       <= 2'd0;
        bus.valid <= 1'b0;
        bus.busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (bus.start) begin
            state    <= ST_SETTLE;
            sel      <= 2'd0;
            bus.busy <= 1'b1;
          end
          ST_SETTLE: if (tc) begin
            bus.data  <= bus.mux_data;
            bus.chan  <= sel;
            bus.valid <= 1'b1;
            state     <= ST_HOLD;
          end
          ST_HOLD: if (bus.ready) begin
            bus.valid <= 1'b0;
            if (sel != LAST_CHAN || bus.cont) begin
              sel   <= sel == LAST_CHAN ? 2'd0 : sel + 2'd1;
              state <= ST_SETTLE;
            end else begin
              sel      <= 2'd0;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state    <= ST_IDLE;
            end
          end
          default: begin
            state     <= ST_IDLE;
            sel       <= 2'd0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed scans on DWELL=4 and DWELL=1 sequencers with a running protocol model
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mux_scan_ctrl_if #(.WIDTH(4)) ia ();
  mux_scan_ctrl_if #(.WIDTH(4)) ib ();
  mux_scan_ctrl #(.DWELL(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  mux_scan_ctrl #(.DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  logic [3:0] tab_a [4] = '{4'd1, 4'd2, 4'd4, 4'd8};
  logic [3:0] tab_b [4] = '{4'd3, 4'd5, 4'd9, 4'd15};
  assign ia.mux_data = tab_a[{ia.s1, ia.s0}];
  assign ib.mux_data = tab_b[{ib.s1, ib.s0}];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // protocol model for the DWELL=4 instance: channel order, settle length, hold stability, idle state
  logic pv, pb, pdn;
  logic [3:0] pd;
  logic [1:0] pc;
  int gap, exp_ch;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pb = 1'b0;
      pdn = 1'b0;
      gap = 0;
      exp_ch = 0;
    end else begin
      if (ia.busy && !pb) exp_ch = 0;
      if (!ia.busy) begin
        chk("idle_sel", {ia.s1, ia.s0}, 0);
        chk("idle_valid", ia.valid, 0);
        gap = 0;
      end
      if (ia.done) chk("done_not_busy", ia.busy, 0);
      if (ia.done && pdn) chk("done_single_cycle", 1, 0);
      if (ia.valid) begin
        chk("valid_chan_is_sel", ia.chan, {ia.s1, ia.s0});
        chk("valid_data_of_chan", ia.data, tab_a[ia.chan]);
        if (!pv) begin
          chk("settle_cycles", gap, 4);
          chk("chan_order", ia.chan, exp_ch);
          exp_ch = (exp_ch + 1) % 4;
        end else begin
          chk("hold_data_stable", ia.data, pd);
          chk("hold_chan_stable", ia.chan, pc);
        end
        gap = 0;
      end else if (ia.busy) gap++;
      pv = ia.valid;
      pd = ia.data;
      pc = ia.chan;
      pb = ia.busy;
      pdn = ia.done;
    end
  end
  initial begin
    int q[$];
    int dcnt;
    {ia.start, ia.cont, ia.abort, ia.ready} = 4'b0;
    {ib.start, ib.cont, ib.abort, ib.ready} = 4'b0;
    tick();
    chk("rst_s0", ia.s0, 0);
    chk("rst_s1", ia.s1, 0);
    chk("rst_data", ia.data, 0);
    chk("rst_chan", ia.chan, 0);
    chk("rst_valid", ia.valid, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    rst_n = 1'b1;
    tick();
    ia.ready = 1'b1;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    chk("single_start_busy", ia.busy, 1);
    chk("single_start_sel", {ia.s1, ia.s0}, 0);
    for (int t = 1; t <= 24; t++) begin
      tick();
      chk("single_valid", ia.valid, int'(t % 5 == 4 && t < 20));
      chk("single_busy", ia.busy, int'(t < 20));
      chk("single_done", ia.done, int'(t == 20));
      if (ia.valid) begin
        chk("single_chan", ia.chan, t / 5);
        chk("single_data", ia.data, 1 << (t / 5));
      end
    end
    ia.ready = 1'b0;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    for (int t = 1; t <= 4; t++) tick();
    chk("stall_ch0_valid", ia.valid, 1);
    chk("stall_ch0_chan", ia.chan, 0);
    ia.ready = 1'b1;
    tick();
    ia.ready = 1'b0;
    chk("stall_ch0_ack_valid", ia.valid, 0);
    chk("stall_ch0_ack_sel", {ia.s1, ia.s0}, 1);
    for (int t = 6; t <= 9; t++) tick();
    for (int t = 9; t <= 18; t++) begin
      chk("stall_valid", ia.valid, 1);
      chk("stall_data", ia.data, 2);
      chk("stall_chan", ia.chan, 1);
      chk("stall_sel", {ia.s1, ia.s0}, 1);
      if (t < 18) tick();
    end
    ia.ready = 1'b1;
    tick();
    chk("stall_release_valid", ia.valid, 0);
    chk("stall_release_sel", {ia.s1, ia.s0}, 2);
    for (int t = 20; t <= 29; t++) begin
      tick();
      chk("stall_done", ia.done, int'(t == 29));
    end
    ia.cont = 1'b1;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    dcnt = 0;
    for (int t = 1; t <= 39; t++) begin
      tick();
      if (t == 30) ia.cont = 1'b0;
      if (ia.valid) q.push_back(int'(ia.chan));
      if (ia.done) dcnt++;
    end
    chk("cont_sample_count", q.size(), 8);
    chk("cont_seq0", q[0], 0);
    chk("cont_seq1", q[1], 1);
    chk("cont_seq2", q[2], 2);
    chk("cont_seq3", q[3], 3);
    chk("cont_seq4", q[4], 0);
    chk("cont_seq5", q[5], 1);
    chk("cont_no_done", dcnt, 0);
    tick();
    chk("cont_stop_done", ia.done, 1);
    chk("cont_stop_busy", ia.busy, 0);
    tick();
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    for (int t = 1; t <= 11; t++) tick();
    chk("abort_pre_sel", {ia.s1, ia.s0}, 2);
    chk("abort_pre_valid", ia.valid, 0);
    ia.abort = 1'b1;
    tick();
    ia.abort = 1'b0;
    chk("abort_busy", ia.busy, 0);
    chk("abort_sel", {ia.s1, ia.s0}, 0);
    chk("abort_valid", ia.valid, 0);
    chk("abort_done", ia.done, 0);
    chk("abort_keep_data", ia.data, 2);
    chk("abort_keep_chan", ia.chan, 1);
    dcnt = 0;
    for (int t = 0; t < 25; t++) begin
      tick();
      if (ia.done || ia.busy) dcnt++;
    end
    chk("abort_quiet", dcnt, 0);
    ia.start = 1'b1;
    ia.abort = 1'b1;
    tick();
    ia.start = 1'b0;
    ia.abort = 1'b0;
    chk("start_abort_busy", ia.busy, 0);
    tick();
    chk("start_abort_stays_idle", ia.busy, 0);
    ia.ready = 1'b0;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    for (int t = 1; t <= 4; t++) tick();
    chk("rst_hold_valid", ia.valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ia.valid, 0);
    chk("async_rst_busy", ia.busy, 0);
    chk("async_rst_sel", {ia.s1, ia.s0}, 0);
    chk("async_rst_data", ia.data, 0);
    chk("async_rst_chan", ia.chan, 0);
    chk("async_rst_done", ia.done, 0);
    #3 rst_n = 1'b1;
    tick();
    ia.ready = 1'b1;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    for (int t = 1; t <= 4; t++) tick();
    chk("restart_valid", ia.valid, 1);
    chk("restart_chan", ia.chan, 0);
    chk("restart_data", ia.data, 1);
    for (int t = 5; t <= 21; t++) tick();
    ib.ready = 1'b1;
    ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    chk("d1_start_busy", ib.busy, 1);
    chk("d1_start_sel", {ib.s1, ib.s0}, 0);
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk("d1_valid", ib.valid, int'(t % 2 == 1 && t < 8));
      chk("d1_done", ib.done, int'(t == 8));
      if (ib.valid) begin
        chk("d1_chan", ib.chan, t / 2);
        chk("d1_data", ib.data, tab_b[t / 2]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
